// File: rtl/inst_rom_loader.sv
// Instruction memory for the fetch stage with a registered read port, plus a
// byte-serial boot loader that fills the memory from a host stream while fetches are held off.
module inst_rom_loader #(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 chip_enable,
   input  logic [31:0]          program_counter,
   output logic [31:0]          instruction,
   output logic                 inst_valid,
   output logic                 fetch_fault,
   input  logic                 load_start,
   input  logic                 load_valid,
   input  logic [7:0]           load_byte,
   input  logic                 load_last,
   output logic                 load_ready,
   output logic                 load_done,
   output logic [ADDR_BITS:0]   word_count
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] LAST_WORD = (ADDR_BITS + 1)'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, LOADING, DONE} state_t;

   logic [31:0] mem [DEPTH];

   state_t               state_q, state_d;
   logic [ADDR_BITS:0]   word_count_q, word_count_d;
   logic [1:0]           byte_idx_q, byte_idx_d;
   logic [31:0]          asm_q, asm_d;
   logic                 load_ready_q, load_ready_d;
   logic                 load_done_q, load_done_d;
   logic [31:0]          instruction_q, instruction_d;
   logic                 inst_valid_q, inst_valid_d;
   logic                 fetch_fault_q, fetch_fault_d;

   logic                 mem_we;
   logic [ADDR_BITS-1:0] mem_waddr;
   logic [31:0]          mem_wdata;
   logic [31:0]          merged;
   logic                 transfer;
   logic [ADDR_BITS-1:0] fetch_idx;
   logic                 fetch_legal;

   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q;
      byte_idx_d   = byte_idx_q;
      asm_d        = asm_q;
      mem_we       = 1'b0;
      mem_waddr    = word_count_q[ADDR_BITS-1:0];
      mem_wdata    = 32'd0;
      transfer     = load_valid & load_ready_q;
      // Byte 0 of each word lands in the most significant lane (big-endian).
      merged       = asm_q | ({24'd0, load_byte} << {2'd3 - byte_idx_q, 3'b000});

      case (state_q)
         IDLE, DONE: begin
            if (load_start) begin
               state_d      = LOADING;
               word_count_d = '0;
               byte_idx_d   = 2'd0;
               asm_d        = 32'd0;
            end
         end
         LOADING: begin
            if (transfer) begin
               if (byte_idx_q == 2'd3 || load_last) begin
                  mem_we       = ~reset;
                  mem_wdata    = merged;
                  word_count_d = word_count_q + (ADDR_BITS + 1)'(1);
                  byte_idx_d   = 2'd0;
                  asm_d        = 32'd0;
                  if (load_last || word_count_q == LAST_WORD) begin
                     state_d = DONE;
                  end
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  asm_d      = merged;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      load_ready_d = (state_d == LOADING);
      load_done_d  = (state_d == DONE);

      // Fetches are suppressed for the whole load session, including the final write edge.
      fetch_idx     = program_counter[ADDR_BITS+1:2];
      fetch_legal   = (program_counter[1:0] == 2'b00) && (program_counter[31:ADDR_BITS+2] == '0);
      instruction_d = 32'd0;
      inst_valid_d  = 1'b0;
      fetch_fault_d = 1'b0;
      if (chip_enable && state_q != LOADING) begin
         if (fetch_legal) begin
            instruction_d = mem[fetch_idx];
            inst_valid_d  = 1'b1;
         end else begin
            fetch_fault_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         word_count_q  <= '0;
         byte_idx_q    <= 2'd0;
         asm_q         <= 32'd0;
         load_ready_q  <= 1'b0;
         load_done_q   <= 1'b0;
         instruction_q <= 32'd0;
         inst_valid_q  <= 1'b0;
         fetch_fault_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         word_count_q  <= word_count_d;
         byte_idx_q    <= byte_idx_d;
         asm_q         <= asm_d;
         load_ready_q  <= load_ready_d;
         load_done_q   <= load_done_d;
         instruction_q <= instruction_d;
         inst_valid_q  <= inst_valid_d;
         fetch_fault_q <= fetch_fault_d;
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign instruction = instruction_q;
   assign inst_valid  = inst_valid_q;
   assign fetch_fault = fetch_fault_q;
   assign load_ready  = load_ready_q;
   assign load_done   = load_done_q;
   assign word_count  = word_count_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed-plus-random bench for inst_rom_loader, checked against a byte-image
// model of memory contents and a plain arithmetic model of fetch legality.
module tb_inst_rom_loader;

   localparam int ADDR_BITS = 10;
   localparam int DEPTH     = 2 ** ADDR_BITS;

   logic                clock = 1'b0;
   logic                reset;
   logic                chip_enable;
   logic [31:0]         program_counter;
   logic [31:0]         instruction;
   logic                inst_valid;
   logic                fetch_fault;
   logic                load_start;
   logic                load_valid;
   logic [7:0]          load_byte;
   logic                load_last;
   logic                load_ready;
   logic                load_done;
   logic [ADDR_BITS:0]  word_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_mem [DEPTH];
   logic [7:0]  byte_q [$];

   inst_rom_loader #(.ADDR_BITS(ADDR_BITS)) dut (
      .clock           (clock),
      .reset           (reset),
      .chip_enable     (chip_enable),
      .program_counter (program_counter),
      .instruction     (instruction),
      .inst_valid      (inst_valid),
      .fetch_fault     (fetch_fault),
      .load_start      (load_start),
      .load_valid      (load_valid),
      .load_byte       (load_byte),
      .load_last       (load_last),
      .load_ready      (load_ready),
      .load_done       (load_done),
      .word_count      (word_count)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Memory image the byte stream should leave behind: byte i goes to word i/4, lane 3 - i%4.
   task automatic model_commit(input bit partial_word_kept, output int words);
      int n;
      n = partial_word_kept ? (byte_q.size() + 3) / 4 : byte_q.size() / 4;
      if (n > DEPTH) n = DEPTH;
      for (int w = 0; w < n; w++) begin
         model_mem[w] = 32'd0;
         for (int b = 0; b < 4; b++) begin
            if (4 * w + b < byte_q.size())
               model_mem[w] = model_mem[w] | (32'(byte_q[4 * w + b]) << (8 * (3 - b)));
         end
      end
      words = n;
   endtask

   task automatic start_load();
      chip_enable     = 1'b1;
      program_counter = 32'd0;
      load_start      = 1'b1;
      step();
      load_start      = 1'b0;
   endtask

   task automatic send_bytes(input bit mark_last, input int count);
      for (int k = 0; k < count; k++) begin
         load_valid = 1'b1;
         load_byte  = byte_q[k];
         load_last  = mark_last && (k == count - 1);
         check("ready_during_load", 32'(load_ready), 32'd1);
         step();
         check("fetch_blocked_while_loading", 32'(inst_valid), 32'd0);
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic finish_checks(input int exp_words);
      check("load_done_set", 32'(load_done), 32'd1);
      check("load_ready_clear", 32'(load_ready), 32'd0);
      check("word_count", 32'(word_count), 32'(exp_words));
      step();
      check("first_fetch_after_done", instruction, model_mem[0]);
      check("first_fetch_valid", 32'(inst_valid), 32'd1);
   endtask

   task automatic fetch_check(input logic ce, input logic [31:0] pc);
      logic        legal;
      logic [31:0] exp_inst;
      chip_enable     = ce;
      program_counter = pc;
      step();
      legal    = (pc % 4 == 0) && (pc < 32'(4 * DEPTH));
      exp_inst = (ce && legal) ? model_mem[pc / 4] : 32'd0;
      check($sformatf("fetch_inst pc=%08h", pc), instruction, exp_inst);
      check($sformatf("fetch_valid pc=%08h", pc), 32'(inst_valid), 32'(ce && legal));
      check($sformatf("fetch_fault pc=%08h", pc), 32'(fetch_fault), 32'(ce && !legal));
   endtask

   initial begin
      int words;
      logic [31:0] pc;

      reset           = 1'b1;
      chip_enable     = 1'b1;
      program_counter = 32'd0;
      load_start      = 1'b0;
      load_valid      = 1'b0;
      load_byte       = 8'd0;
      load_last       = 1'b0;

      for (int c = 0; c < 2; c++) begin
         step();
         check("rst_instruction", instruction, 32'd0);
         check("rst_inst_valid", 32'(inst_valid), 32'd0);
         check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
         check("rst_load_ready", 32'(load_ready), 32'd0);
         check("rst_load_done", 32'(load_done), 32'd0);
         check("rst_word_count", 32'(word_count), 32'd0);
      end
      reset       = 1'b0;
      chip_enable = 1'b0;
      step();
      check("idle_load_ready", 32'(load_ready), 32'd0);
      check("idle_load_done", 32'(load_done), 32'd0);

      $display("[TB] eight-byte image");
      byte_q = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h20, 8'h42, 8'h00, 8'h0A};
      start_load();
      send_bytes(1'b1, 8);
      model_commit(1'b1, words);
      check("model_word0", model_mem[0], 32'h34010005);
      finish_checks(words);
      fetch_check(1'b1, 32'd4);
      check("literal_word1", instruction, 32'h2042000A);
      fetch_check(1'b0, 32'd4);

      $display("[TB] partial last word");
      byte_q = '{8'hAA, 8'hBB};
      start_load();
      send_bytes(1'b1, 2);
      model_commit(1'b1, words);
      finish_checks(words);
      check("partial_word_literal", instruction, 32'hAABB0000);
      fetch_check(1'b1, 32'd4);

      $display("[TB] full random image without load_last");
      byte_q.delete();
      for (int k = 0; k < 4 * DEPTH; k++) byte_q.push_back(8'($urandom));
      start_load();
      send_bytes(1'b0, 4 * DEPTH);
      model_commit(1'b0, words);
      finish_checks(words);
      load_valid = 1'b1;
      load_byte  = 8'h5A;
      check("byte_4097_not_ready", 32'(load_ready), 32'd0);
      step();
      load_valid = 1'b0;
      check("count_holds_at_full", 32'(word_count), 32'(DEPTH));
      check("done_holds_at_full", 32'(load_done), 32'd1);

      fetch_check(1'b1, 32'd0);
      fetch_check(1'b1, 32'd4);
      fetch_check(1'b1, 32'd8);
      fetch_check(1'b1, 32'h00000002);
      fetch_check(1'b1, 32'h00001000);
      fetch_check(1'b1, 32'h00000FFC);
      fetch_check(1'b1, 32'h80000000);
      for (int r = 0; r < 40; r++) begin
         pc = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4 * DEPTH + 64));
         if ($urandom_range(0, 1) == 0) pc = pc & ~32'd3;
         fetch_check(1'($urandom_range(0, 4) != 0), pc);
      end

      $display("[TB] reset in the middle of a load");
      byte_q.delete();
      for (int k = 0; k < 6; k++) byte_q.push_back(8'($urandom));
      start_load();
      send_bytes(1'b0, 6);
      model_commit(1'b0, words);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_word_count", 32'(word_count), 32'd0);
      check("midrst_load_ready", 32'(load_ready), 32'd0);
      check("midrst_load_done", 32'(load_done), 32'd0);
      fetch_check(1'b1, 32'd0);
      fetch_check(1'b1, 32'd4);

      byte_q.delete();
      for (int k = 0; k < 4; k++) byte_q.push_back(8'($urandom));
      start_load();
      send_bytes(1'b1, 4);
      model_commit(1'b1, words);
      finish_checks(words);
      fetch_check(1'b1, 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
